// File: rtl/riscv_pkg.sv
// Shared RISC-V core types and constants used by the fetch stage.
package riscv_pkg;

    localparam int XLEN = 32;

    // addi x0, x0, 0
    localparam logic [XLEN-1:0] NOP_INSTR        = 32'h0000_0013;
    localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

    // One fetched instruction together with the address it came from.
    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } fetch_entry_t;

    // Sequential fetch address; wraps silently at the top of the address space.
    function automatic logic [XLEN-1:0] next_pc(input logic [XLEN-1:0] pc);
        return pc + XLEN'(4);
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO with flush and occupancy count. DEPTH must be a
// power of two so the pointers wrap naturally.
module fetch_fifo
    import riscv_pkg::*;
#(
    parameter int  DEPTH = 2,
    parameter type T     = fetch_entry_t,
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk_i,
    input  logic             rstn_i,
    input  logic             flush_i,
    input  logic             push_i,
    input  T                 data_i,
    input  logic             pop_i,
    output T                 data_o,
    output logic [CNT_W-1:0] count_o
);

    T                 mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             do_push;
    logic             do_pop;

    // A pop on empty is ignored; a push on full is accepted only alongside a pop.
    assign do_pop  = pop_i && (count_q != '0);
    assign do_push = push_i && !flush_i && ((count_q != CNT_W'(DEPTH)) || do_pop);

    // Storage write port.
    // NOTE: the data array is deliberately left without reset; valid data is
    // defined by the pointers and count, and an unreset array maps onto plain RAM.
    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

    // Pointer and occupancy bookkeeping; flush empties the FIFO in one cycle.
    // NOTE: every sequential assignment is non-blocking so all registers sample
    // the pre-edge values and the block order does not matter.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            count_q <= count_q + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    assign data_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/fetch.sv
// Instruction-fetch stage: owns the PC, issues credit-limited in-order
// requests to instruction memory, buffers responses and presents registered
// pc/instruction pairs to decode. Redirects flush local state and discard
// every response still in flight.
// Optional build macro FETCH_MISALIGN_CHECK_EN adds misaligned_o and halts
// fetch after a redirect to a non word-aligned target.
module fetch
    import riscv_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC  = RESET_PC_DEFAULT,
    parameter int              BUF_DEPTH = 2
) (
    input  logic            clk_i,
    input  logic            rstn_i,
    output logic            imem_req_valid_o,
    input  logic            imem_req_ready_i,
    output logic [XLEN-1:0] imem_req_addr_o,
    input  logic            imem_rsp_valid_i,
    input  logic [XLEN-1:0] imem_rsp_data_i,
    input  logic            redirect_valid_i,
    input  logic [XLEN-1:0] redirect_pc_i,
    input  logic            stall_i,
    output logic [XLEN-1:0] pc_o,
    output logic [XLEN-1:0] instruction_o,
    output logic            valid_o
`ifdef FETCH_MISALIGN_CHECK_EN
    ,
    output logic            misaligned_o
`endif
);

    localparam int               CNT_W   = $clog2(BUF_DEPTH + 1);
    localparam logic [CNT_W:0]   DEPTH_W = (CNT_W + 1)'(BUF_DEPTH);

    logic [XLEN-1:0]  pc_q;
    logic [XLEN-1:0]  pc_d;
    logic [CNT_W-1:0] outstanding_q;
    logic [CNT_W-1:0] outstanding_d;
    logic [CNT_W-1:0] drop_cnt_q;
    logic [CNT_W-1:0] drop_cnt_d;

    logic [XLEN-1:0]  pc_out_q;
    logic [XLEN-1:0]  instr_q;
    logic             valid_q;

    logic [CNT_W-1:0] buf_count;
    logic [CNT_W-1:0] pcq_count;
    fetch_entry_t     buf_head;
    fetch_entry_t     buf_push_entry;
    logic [XLEN-1:0]  pcq_head;

    logic             credit;
    logic             fetch_halt;
    logic             req_fire;
    logic             rsp_dec;
    logic             rsp_drop;
    logic             rsp_accept;
    logic             buf_empty;
    logic             out_pop;
    logic             out_bypass;
    logic             buf_push;
    logic [XLEN-1:0]  redirect_target;

`ifdef FETCH_MISALIGN_CHECK_EN
    logic misaligned_q;

    // Sticky misalignment flag: set by a misaligned redirect, cleared by an aligned one.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            misaligned_q <= 1'b0;
        end else if (redirect_valid_i) begin
            misaligned_q <= (redirect_pc_i[1:0] != 2'b00);
        end
    end

    assign redirect_target = redirect_pc_i;
    assign fetch_halt      = misaligned_q;
    assign misaligned_o    = misaligned_q;
`else
    // Low address bits are not meaningful without the check; force word alignment.
    assign redirect_target = redirect_pc_i & ~XLEN'(3);
    assign fetch_halt      = 1'b0;
`endif

    // Every request reserves a buffer slot up front, so a response can never
    // find the buffer full and the memory never needs back-pressure.
    assign credit = ({1'b0, outstanding_q} + {1'b0, buf_count}) < DEPTH_W;

    assign imem_req_valid_o = credit && !redirect_valid_i && !fetch_halt;
    assign imem_req_addr_o  = pc_q;
    assign req_fire         = imem_req_valid_o && imem_req_ready_i;

    // A response is stale if it belongs to a fetch issued before a redirect,
    // including one that arrives in the redirect cycle itself.
    assign rsp_dec    = imem_rsp_valid_i && (outstanding_q != '0);
    assign rsp_drop   = rsp_dec && (redirect_valid_i || (drop_cnt_q != '0));
    assign rsp_accept = rsp_dec && !rsp_drop && (pcq_count != '0);

    assign buf_empty  = (buf_count == '0);
    assign out_pop    = !redirect_valid_i && !stall_i && !buf_empty;
    assign out_bypass = !redirect_valid_i && !stall_i && buf_empty && rsp_accept;
    assign buf_push   = rsp_accept && !out_bypass;

    assign buf_push_entry = '{pc: pcq_head, instr: imem_rsp_data_i};

    // Addresses of issued requests, in issue order, to tag their responses.
    fetch_fifo #(
        .DEPTH (BUF_DEPTH),
        .T     (logic [XLEN-1:0])
    ) u_pc_queue (
        .clk_i   (clk_i),
        .rstn_i  (rstn_i),
        .flush_i (redirect_valid_i),
        .push_i  (req_fire),
        .data_i  (pc_q),
        .pop_i   (rsp_accept),
        .data_o  (pcq_head),
        .count_o (pcq_count)
    );

    // Returned instructions waiting for decode.
    fetch_fifo #(
        .DEPTH (BUF_DEPTH),
        .T     (fetch_entry_t)
    ) u_inst_buf (
        .clk_i   (clk_i),
        .rstn_i  (rstn_i),
        .flush_i (redirect_valid_i),
        .push_i  (buf_push),
        .data_i  (buf_push_entry),
        .pop_i   (out_pop),
        .data_o  (buf_head),
        .count_o (buf_count)
    );

    // Next PC and in-flight/drop counters; a redirect overrides sequential fetch.
    // NOTE: each variable gets its hold value first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        pc_d          = pc_q;
        outstanding_d = outstanding_q;
        drop_cnt_d    = drop_cnt_q;

        if (req_fire) begin
            pc_d          = next_pc(pc_q);
            outstanding_d = outstanding_q + CNT_W'(1);
        end
        if (rsp_dec) begin
            outstanding_d = outstanding_d - CNT_W'(1);
        end

        if (redirect_valid_i) begin
            pc_d = redirect_target;
            // Everything still in flight after this cycle is stale. Any
            // same-cycle response is one of them and is already consumed.
            drop_cnt_d = outstanding_q - CNT_W'(rsp_dec);
        end else if (rsp_drop) begin
            drop_cnt_d = drop_cnt_q - CNT_W'(1);
        end
    end

    // PC and counter registers.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            pc_q          <= RESET_PC;
            outstanding_q <= '0;
            drop_cnt_q    <= '0;
        end else begin
            pc_q          <= pc_d;
            outstanding_q <= outstanding_d;
            drop_cnt_q    <= drop_cnt_d;
        end
    end

    // Decode-facing output register: redirect bubble, then buffer head, then bypass.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            valid_q  <= 1'b0;
            pc_out_q <= '0;
            instr_q  <= NOP_INSTR;
        end else if (redirect_valid_i) begin
            valid_q  <= 1'b0;
            instr_q  <= NOP_INSTR;
        end else if (!stall_i) begin
            if (out_pop) begin
                valid_q  <= 1'b1;
                pc_out_q <= buf_head.pc;
                instr_q  <= buf_head.instr;
            end else if (out_bypass) begin
                valid_q  <= 1'b1;
                pc_out_q <= pcq_head;
                instr_q  <= imem_rsp_data_i;
            end else begin
                valid_q  <= 1'b0;
                instr_q  <= NOP_INSTR;
            end
        end
    end

    assign valid_o       = valid_q;
    assign pc_o          = pc_out_q;
    assign instruction_o = instr_q;

    // Memory must never answer a request that was not issued.
    rsp_without_request: assert property (
        @(posedge clk_i) disable iff (!rstn_i) imem_rsp_valid_i |-> (outstanding_q != '0)
    );

endmodule
